// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: two-master round-robin arbiter for the serial bus.
// A grant is held for one transfer; rx_done, abandon or timeout ends it.
module serial_bus_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic req2,
  input  logic m1_valid,
  input  logic m2_valid,
  input  logic m1_rx_address,
  input  logic m2_rx_address,
  input  logic m1_rx_data,
  input  logic m2_rx_data,
  input  logic m1_write_en,
  input  logic m2_write_en,
  input  logic m1_read_en,
  input  logic m2_read_en,
  input  logic rx_done,
  input  logic slave_ready,
  output logic grant1,
  output logic grant2,
  output logic rx_address,
  output logic rx_data,
  output logic master_valid,
  output logic write_en,
  output logic read_en,
  output logic m1_slave_ready,
  output logic m2_slave_ready,
  output logic bus_busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    RELEASE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic       grant1_nx;
  logic       grant2_nx;
  logic       last;
  logic       last_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       err_nx;
  logic       req_g;
  logic       valid_g;
  logic       quit;
  logic       expire;
  logic       pick1;
  logic       pick2;

  // last: 0 = master 1 held the bus last, 1 = master 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant1      <= 1'b0;
      grant2      <= 1'b0;
      last        <= 1'b1;
      cnt         <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      grant1      <= grant1_nx;
      grant2      <= grant2_nx;
      last        <= last_nx;
      cnt         <= cnt_nx;
      timeout_err <= err_nx;
    end
  end

  always_comb begin
    req_g   = (grant1 & req1) | (grant2 & req2);
    valid_g = (grant1 & m1_valid) | (grant2 & m2_valid);
    quit    = !req_g && !valid_g;
    expire  = (cnt == CNT_LAST);
    pick1   = req1 && (!req2 || last);
    pick2   = req2 && !pick1;
  end

  always_comb begin
    state_nx  = state;
    grant1_nx = grant1;
    grant2_nx = grant2;
    last_nx   = last;
    cnt_nx    = cnt;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        unique case (1'b1)
          pick1: begin
            grant1_nx = 1'b1;
            last_nx   = 1'b0;
            cnt_nx    = 8'd0;
            state_nx  = GRANTED;
          end
          pick2: begin
            grant2_nx = 1'b1;
            last_nx   = 1'b1;
            cnt_nx    = 8'd0;
            state_nx  = GRANTED;
          end
          default: ;
        endcase
      end
      GRANTED: begin
        if (rx_done || quit || expire) begin
          state_nx  = RELEASE;
          grant1_nx = 1'b0;
          grant2_nx = 1'b0;
          // error only when the timeout alone ends the grant
          err_nx    = !rx_done && !quit;
        end else if (cnt != 8'hFF) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      RELEASE: begin
        state_nx  = IDLE;
        grant1_nx = 1'b0;
        grant2_nx = 1'b0;
      end
      default: begin
        state_nx  = IDLE;
        grant1_nx = 1'b0;
        grant2_nx = 1'b0;
      end
    endcase
  end

  always_comb begin
    rx_address     = (grant1 & m1_rx_address) | (grant2 & m2_rx_address);
    rx_data        = (grant1 & m1_rx_data) | (grant2 & m2_rx_data);
    master_valid   = valid_g;
    write_en       = (grant1 & m1_write_en) | (grant2 & m2_write_en);
    read_en        = (grant1 & m1_read_en) | (grant2 & m2_read_en);
    m1_slave_ready = grant1 & slave_ready;
    m2_slave_ready = grant2 & slave_ready;
    bus_busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed bench with a transaction-level model
// of grant ownership, cooldown and timeout, checked every cycle.
module tb_serial_bus_arbiter;

  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req1 = 0, req2 = 0;
  logic m1_valid = 0, m2_valid = 0;
  logic m1_rx_address = 0, m2_rx_address = 0;
  logic m1_rx_data = 0, m2_rx_data = 0;
  logic m1_write_en = 0, m2_write_en = 0;
  logic m1_read_en = 0, m2_read_en = 0;
  logic rx_done = 0, slave_ready = 0;
  logic grant1, grant2, rx_address, rx_data, master_valid;
  logic write_en, read_en, m1_slave_ready, m2_slave_ready;
  logic bus_busy, timeout_err;

  serial_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req1(req1), .req2(req2),
    .m1_valid(m1_valid), .m2_valid(m2_valid),
    .m1_rx_address(m1_rx_address), .m2_rx_address(m2_rx_address),
    .m1_rx_data(m1_rx_data), .m2_rx_data(m2_rx_data),
    .m1_write_en(m1_write_en), .m2_write_en(m2_write_en),
    .m1_read_en(m1_read_en), .m2_read_en(m2_read_en),
    .rx_done(rx_done), .slave_ready(slave_ready),
    .grant1(grant1), .grant2(grant2),
    .rx_address(rx_address), .rx_data(rx_data),
    .master_valid(master_valid), .write_en(write_en), .read_en(read_en),
    .m1_slave_ready(m1_slave_ready), .m2_slave_ready(m2_slave_ready),
    .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: who owns the bus, edges held, edges of forced idle left
  int m_owner = 0;
  int m_age = 0;
  int m_cool = 0;
  int m_last = 2;
  bit m_err = 0;
  bit m_rq, m_vl, m_quit;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = 0; m_age = 0; m_cool = 0; m_last = 2; m_err = 0;
    end else begin
      m_err = 0;
      if (m_owner != 0) begin
        m_rq = (m_owner == 1) ? req1 : req2;
        m_vl = (m_owner == 1) ? m1_valid : m2_valid;
        m_quit = !m_rq && !m_vl;
        m_age++;
        if (rx_done || m_quit || m_age >= TIMEOUT) begin
          m_err = !rx_done && !m_quit;
          m_owner = 0;
          m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (req1 || req2) begin
        if (req1 && req2) m_owner = (m_last == 1) ? 2 : 1;
        else m_owner = req1 ? 1 : 2;
        m_last = m_owner;
        m_age = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("grant1", grant1, m_owner == 1);
    chk("grant2", grant2, m_owner == 2);
    chk("bus_busy", bus_busy, (m_owner != 0) || (m_cool != 0));
    chk("timeout_err", timeout_err, m_err);
    chk("rx_address", rx_address,
        m_owner == 1 ? m1_rx_address : m_owner == 2 ? m2_rx_address : 1'b0);
    chk("rx_data", rx_data,
        m_owner == 1 ? m1_rx_data : m_owner == 2 ? m2_rx_data : 1'b0);
    chk("master_valid", master_valid,
        m_owner == 1 ? m1_valid : m_owner == 2 ? m2_valid : 1'b0);
    chk("write_en", write_en,
        m_owner == 1 ? m1_write_en : m_owner == 2 ? m2_write_en : 1'b0);
    chk("read_en", read_en,
        m_owner == 1 ? m1_read_en : m_owner == 2 ? m2_read_en : 1'b0);
    chk("m1_slave_ready", m1_slave_ready, (m_owner == 1) && slave_ready);
    chk("m2_slave_ready", m2_slave_ready, (m_owner == 2) && slave_ready);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_grant(output int who);
    for (int i = 0; i < 10 && !(grant1 || grant2); i++) step();
    who = grant1 ? 1 : (grant2 ? 2 : 0);
    chk("grant_wait", who != 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int who, held, errs;
  int order[4];
  int gcyc[4];
  int rcyc[4];
  logic [11:0] addr, cap_a;
  logic [7:0] dat, cap_d;

  initial begin
    slave_ready = 1'b1;
    step();
    step();
    chk("rst_grant1", grant1, 0);
    chk("rst_grant2", grant2, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_err", timeout_err, 0);
    reset = 1'b1;
    step();

    // stray rx_done in IDLE, then a single master-1 write
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    req1 = 1'b1;
    step();
    chk("t1_grant1", grant1, 1);
    addr = 12'h5A3;
    dat = 8'hC6;
    m1_valid = 1'b1;
    m1_write_en = 1'b1;
    for (int b = 11; b >= 0; b--) begin
      m1_rx_address = addr[b];
      #1;
      cap_a = {cap_a[10:0], rx_address};
      step();
      m1_write_en = 1'b0;
    end
    for (int b = 7; b >= 0; b--) begin
      m1_rx_data = dat[b];
      #1;
      cap_d = {cap_d[6:0], rx_data};
      step();
    end
    chk("t1_addr", cap_a, 32'h5A3);
    chk("t1_data", cap_d, 32'hC6);
    m1_valid = 1'b0;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    req1 = 1'b0;
    chk("t1_rel_grant", grant1, 0);
    chk("t1_rel_busy", bus_busy, 1);
    step();
    chk("t1_idle_busy", bus_busy, 0);

    // contention: alternating grants, 2-cycle gap
    do_reset();
    m1_write_en = 1'b1;
    m2_read_en = 1'b1;
    m2_rx_data = 1'b1;
    req1 = 1'b1;
    req2 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_grant(who);
      order[n] = who;
      gcyc[n] = cyc;
      repeat (14) step();
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      rcyc[n] = cyc;
    end
    req1 = 1'b0;
    req2 = 1'b0;
    m1_write_en = 1'b0;
    m2_read_en = 1'b0;
    m2_rx_data = 1'b0;
    chk("t2_order0", order[0], 1);
    chk("t2_order1", order[1], 2);
    chk("t2_order2", order[2], 1);
    chk("t2_order3", order[3], 2);
    for (int n = 0; n < 3; n++) begin
      chk("t2_gap", gcyc[n+1] - rcyc[n], 2);
      chk("t2_hold", rcyc[n] - gcyc[n], 15);
    end
    step();
    step();

    // timeout with master 2 never valid
    do_reset();
    req2 = 1'b1;
    wait_grant(who);
    chk("t3_who", who, 2);
    held = 0;
    errs = 0;
    while (grant2 && held < 100) begin
      step();
      held++;
      if (timeout_err) errs++;
    end
    req2 = 1'b0;
    chk("t3_err_now", timeout_err, 1);
    step();
    if (timeout_err) errs++;
    chk("t3_held", held, 64);
    chk("t3_err_cnt", errs, 1);
    step();

    // rx_done on the timeout cycle
    do_reset();
    req1 = 1'b1;
    m1_valid = 1'b1;
    m1_read_en = 1'b1;
    wait_grant(who);
    repeat (63) step();
    chk("t4_still", grant1, 1);
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    req1 = 1'b0;
    m1_valid = 1'b0;
    m1_read_en = 1'b0;
    chk("t4_grant", grant1, 0);
    chk("t4_err", timeout_err, 0);
    step();
    step();

    // master 1 abandons, master 2 takes over
    do_reset();
    req1 = 1'b1;
    req2 = 1'b1;
    wait_grant(who);
    chk("t5_who", who, 1);
    step();
    step();
    req1 = 1'b0;
    step();
    chk("t5_rel", grant1, 0);
    chk("t5_err", timeout_err, 0);
    step();
    chk("t5_gap", grant2, 0);
    step();
    chk("t5_g2", grant2, 1);
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    req2 = 1'b0;
    step();
    step();

    // async reset during address bit 5
    do_reset();
    req1 = 1'b1;
    m1_valid = 1'b1;
    wait_grant(who);
    for (int b = 11; b >= 5; b--) begin
      m1_rx_address = addr[b];
      if (b == 5) begin
        #1;
        chk("t6_pre_addr", rx_address, 1);
        chk("t6_pre_valid", master_valid, 1);
        reset = 1'b0;
        #1;
        chk("t6_grant", grant1, 0);
        chk("t6_valid", master_valid, 0);
        chk("t6_addr", rx_address, 0);
      end else begin
        step();
      end
    end
    req2 = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("t6_tie_g1", grant1, 1);
    chk("t6_tie_g2", grant2, 0);
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
    m1_valid = 1'b0;
    m1_rx_address = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
